vga_scan_out: RTL and testbench



---
 rtl/vga_scan_out.sv | 117 +++++++++++
 tb/tb_vga_scan_out.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_out.sv
// 640x480@60 VGA scan-out for a 320x240x4bpp frame buffer with 2x2 pixel doubling.
// Counter state at cycle n reaches the pins at n+3: address reg, buffer read reg, output reg.
module vga_scan_out #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int FB_WIDTH = 320
) (
  input  logic        gpu_clk,
  input  logic        gpu_rst_n,
  output logic [16:0] vga_pixel_addr,
  input  logic [3:0]  vga_pixel_data,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_de,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        frame_start,
  output logic        vblank
);

  localparam int STAGES  = 3;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  V_ACT_M1 = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [16:0] ROW_STEP = 17'(FB_WIDTH);

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
    logic fstart;
    logic vblank;
  } ctl_t;

  localparam ctl_t CTL_IDLE = '{hsync: 1'b1, vsync: 1'b1, de: 1'b0, fstart: 1'b0, vblank: 1'b0};

  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [16:0] row_base_q, row_base_d, addr_q, addr_d;
  logic [3:0]  rgb_q, rgb_d;
  ctl_t [STAGES-1:0] ctl_pipe_q, ctl_pipe_d;
  ctl_t        ctl_raw;
  logic        h_wrap, v_wrap, active;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = h_wrap && (v_cnt_q == V_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;

    active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

    // Base steps one buffer row every two display lines; it is dropped after the
    // last visible line so it never points past the final row.
    row_base_d = row_base_q;
    if (h_wrap) begin
      if (v_wrap || v_cnt_q == V_ACT_M1)       row_base_d = '0;
      else if (v_cnt_q[0] && v_cnt_q < V_ACT)  row_base_d = row_base_q + ROW_STEP;
    end
    addr_d = active ? row_base_q + {8'd0, h_cnt_q[9:1]} : '0;

    ctl_raw.hsync  = !(h_cnt_q >= HS_BEG && h_cnt_q < HS_END);
    ctl_raw.vsync  = !(v_cnt_q >= VS_BEG && v_cnt_q < VS_END);
    ctl_raw.de     = active;
    ctl_raw.fstart = (h_cnt_q == '0) && (v_cnt_q == '0);
    ctl_raw.vblank = (v_cnt_q >= V_ACT);

    ctl_pipe_d = {ctl_pipe_q[STAGES-2:0], ctl_raw};
    // Buffer data now belongs to stage STAGES-2; blank it with that stage's enable.
    rgb_d = ctl_pipe_q[STAGES-2].de ? vga_pixel_data : '0;
  end

  always_ff @(posedge gpu_clk or negedge gpu_rst_n) begin
    if (!gpu_rst_n) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      rgb_q      <= '0;
      ctl_pipe_q <= {STAGES{CTL_IDLE}};
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      rgb_q      <= rgb_d;
      ctl_pipe_q <= ctl_pipe_d;
    end
  end

  assign vga_pixel_addr = addr_q;
  assign vga_hsync      = ctl_pipe_q[STAGES-1].hsync;
  assign vga_vsync      = ctl_pipe_q[STAGES-1].vsync;
  assign vga_de         = ctl_pipe_q[STAGES-1].de;
  assign frame_start    = ctl_pipe_q[STAGES-1].fstart;
  assign vblank         = ctl_pipe_q[STAGES-1].vblank;
  assign vga_r          = rgb_q;
  assign vga_g          = rgb_q;
  assign vga_b          = rgb_q;

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out: full-size instance with hand-computed vectors over the first
// lines, plus a shrunken-geometry instance scanned over several whole frames.
module tb_vga_scan_out;

  logic gpu_clk = 1'b0;
  always #5 gpu_clk = ~gpu_clk;

  typedef struct packed {
    logic de, hs, vs, fs, vb;
    logic [16:0] addr;
    logic [3:0] r, g, b;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t e;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  int tcyc_a, tcyc_b;

  logic rst_a, rst_b;
  logic [16:0] addr_a, addr_b;
  logic [3:0]  fb_a, fb_b, r_a, g_a, b_a, r_b, g_b, b_b;
  logic hs_a, vs_a, de_a, fs_a, vb_a, hs_b, vs_b, de_b, fs_b, vb_b;
  obs_t obs_a, obs_b;

  assign obs_a = {de_a, hs_a, vs_a, fs_a, vb_a, addr_a, r_a, g_a, b_a};
  assign obs_b = {de_b, hs_b, vs_b, fs_b, vb_b, addr_b, r_b, g_b, b_b};

  vga_scan_out u_big (
    .gpu_clk(gpu_clk), .gpu_rst_n(rst_a), .vga_pixel_addr(addr_a), .vga_pixel_data(fb_a),
    .vga_hsync(hs_a), .vga_vsync(vs_a), .vga_de(de_a), .vga_r(r_a), .vga_g(g_a), .vga_b(b_a),
    .frame_start(fs_a), .vblank(vb_a));

  vga_scan_out #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                 .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .FB_WIDTH(4)) u_small (
    .gpu_clk(gpu_clk), .gpu_rst_n(rst_b), .vga_pixel_addr(addr_b), .vga_pixel_data(fb_b),
    .vga_hsync(hs_b), .vga_vsync(vs_b), .vga_de(de_b), .vga_r(r_b), .vga_g(g_b), .vga_b(b_b),
    .frame_start(fs_b), .vblank(vb_b));

  // Cycle index since reset release: 0 before the first edge, k after k edges.
  always @(posedge gpu_clk or negedge rst_a)
    if (!rst_a) tcyc_a <= 0; else tcyc_a <= tcyc_a + 1;
  always @(posedge gpu_clk or negedge rst_b)
    if (!rst_b) tcyc_b <= 0; else tcyc_b <= tcyc_b + 1;

  // Address shown in cycle c came from raster state c-1.
  function automatic bit act_at(int c, int ht, int ha, int vt, int va);
    int x, y;
    if (c < 1) return 1'b0;
    x = (c - 1) % ht;
    y = ((c - 1) / ht) % vt;
    return (x < ha) && (y < va);
  endfunction

  // Frame buffer: pixel[k] = k[3:0]; reads of blank-time addresses return junk 0xF.
  always @(posedge gpu_clk) begin
    fb_a <= act_at(tcyc_a, 800, 640, 525, 480) ? addr_a[3:0] : 4'hF;
    fb_b <= act_at(tcyc_b, 16, 8, 10, 6) ? addr_b[3:0] : 4'hF;
  end

  function automatic obs_t model(int c, int ht, int ha, int hfp, int hsw,
                                 int vt, int va, int vfp, int vsw, int fbw);
    obs_t o;
    int s, x, y;
    o.de = 1'b0; o.hs = 1'b1; o.vs = 1'b1; o.fs = 1'b0; o.vb = 1'b0;
    o.addr = '0; o.r = '0; o.g = '0; o.b = '0;
    if (c >= 1) begin
      s = c - 1; x = s % ht; y = (s / ht) % vt;
      if (x < ha && y < va) o.addr = 17'((y / 2) * fbw + x / 2);
    end
    if (c >= 3) begin
      s = c - 3; x = s % ht; y = (s / ht) % vt;
      o.de = (x < ha) && (y < va);
      o.hs = !((x >= ha + hfp) && (x < ha + hfp + hsw));
      o.vs = !((y >= va + vfp) && (y < va + vfp + vsw));
      o.fs = (x == 0) && (y == 0);
      o.vb = (y >= va);
      if (o.de) begin
        o.r = 4'((y / 2) * fbw + x / 2);
        o.g = o.r;
        o.b = o.r;
      end
    end
    return o;
  endfunction

  function automatic obs_t mb(int c);
    return model(c, 800, 640, 16, 96, 525, 480, 10, 2, 320);
  endfunction

  function automatic obs_t ms(int c);
    return model(c, 16, 8, 2, 3, 10, 6, 1, 2, 4);
  endfunction

  function automatic vec_t mk(int cyc, bit de, bit hs, bit vs, bit fs, bit vb, int addr, int rgb);
    vec_t v;
    v.cyc = cyc;
    v.e.de = de; v.e.hs = hs; v.e.vs = vs; v.e.fs = fs; v.e.vb = vb;
    v.e.addr = 17'(addr);
    v.e.r = 4'(rgb); v.e.g = 4'(rgb); v.e.b = 4'(rgb);
    return v;
  endfunction

  task automatic check(string nm, int c, obs_t act, obs_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got de=%b hs=%b vs=%b fs=%b vb=%b addr=%0d rgb=%h/%h/%h want de=%b hs=%b vs=%b fs=%b vb=%b addr=%0d rgb=%h/%h/%h",
                  nm, c, act.de, act.hs, act.vs, act.fs, act.vb, act.addr, act.r, act.g, act.b,
                  exp.de, exp.hs, exp.vs, exp.fs, exp.vb, exp.addr, exp.r, exp.g, exp.b);
  endtask

  task automatic check_int(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s got=%0d want=%0d", nm, act, exp);
  endtask

  task automatic wait_a(int c);
    int guard = 0;
    while (tcyc_a < c && guard < 20000) begin @(negedge gpu_clk); guard++; end
  endtask

  task automatic wait_b(int c);
    int guard = 0;
    while (tcyc_b < c && guard < 20000) begin @(negedge gpu_clk); guard++; end
  endtask

  vec_t vec[$];
  int   fs_q[$];

  initial begin
    rst_a = 1'b0;
    rst_b = 1'b0;

    //             cyc   de hs vs fs vb addr rgb
    vec.push_back(mk(0,    0, 1, 1, 0, 0, 0,   0));
    vec.push_back(mk(1,    0, 1, 1, 0, 0, 0,   0));
    vec.push_back(mk(2,    0, 1, 1, 0, 0, 0,   0));
    vec.push_back(mk(3,    1, 1, 1, 1, 0, 1,   0));
    vec.push_back(mk(4,    1, 1, 1, 0, 0, 1,   0));
    vec.push_back(mk(5,    1, 1, 1, 0, 0, 2,   1));
    vec.push_back(mk(7,    1, 1, 1, 0, 0, 3,   2));
    vec.push_back(mk(35,   1, 1, 1, 0, 0, 17,  0));
    vec.push_back(mk(642,  1, 1, 1, 0, 0, 0,   15));
    vec.push_back(mk(643,  0, 1, 1, 0, 0, 0,   0));
    vec.push_back(mk(658,  0, 1, 1, 0, 0, 0,   0));
    vec.push_back(mk(659,  0, 0, 1, 0, 0, 0,   0));
    vec.push_back(mk(754,  0, 0, 1, 0, 0, 0,   0));
    vec.push_back(mk(755,  0, 1, 1, 0, 0, 0,   0));
    vec.push_back(mk(801,  0, 1, 1, 0, 0, 0,   0));
    vec.push_back(mk(803,  1, 1, 1, 0, 0, 1,   0));
    vec.push_back(mk(1441, 1, 1, 1, 0, 0, 0,   15));
    vec.push_back(mk(1601, 0, 1, 1, 0, 0, 320, 0));
    vec.push_back(mk(1604, 1, 1, 1, 0, 0, 321, 0));
    vec.push_back(mk(1606, 1, 1, 1, 0, 0, 322, 1));
    vec.push_back(mk(2403, 1, 1, 1, 0, 0, 321, 0));
    vec.push_back(mk(2405, 1, 1, 1, 0, 0, 322, 1));
    vec.push_back(mk(3201, 0, 1, 1, 0, 0, 640, 0));
    vec.push_back(mk(3213, 1, 1, 1, 0, 0, 646, 5));

    repeat (3) @(negedge gpu_clk);
    check("big_in_reset", 0, obs_a, mk(0, 0, 1, 1, 0, 0, 0, 0).e);
    rst_a = 1'b1;
    #1;
    foreach (vec[i]) begin
      wait_a(vec[i].cyc);
      check("big_vec", vec[i].cyc, obs_a, vec[i].e);
    end

    // Mid-frame reset on the full-size raster: line 4, pixel 300 at the outputs.
    wait_a(4 * 800 + 300 + 3);
    check("big_pre_rst", tcyc_a, obs_a, mb(tcyc_a));
    rst_a = 1'b0;
    #1;
    check("big_rst_now", 0, obs_a, mb(0));
    repeat (5) begin
      @(negedge gpu_clk);
      check("big_rst_hold", 0, obs_a, mb(0));
    end
    rst_a = 1'b1;
    #1;
    for (int c = 0; c <= 8; c++) begin
      wait_a(c);
      check("big_restart", c, obs_a, mb(c));
    end

    // Shrunken geometry: 16x10 total, 160 clocks per frame, three frames and change.
    @(negedge gpu_clk);
    rst_b = 1'b1;
    #1;
    for (int c = 0; c < 500; c++) begin
      wait_b(c);
      check("small_scan", c, obs_b, ms(c));
      if (fs_b) fs_q.push_back(c);
    end
    check_int("fs_count", fs_q.size(), 4);
    for (int i = 0; i < 4 && i < fs_q.size(); i++)
      check_int("fs_period", fs_q[i], 3 + 160 * i);

    wait_b(480 + 3 * 16 + 5 + 3);
    check("small_pre_rst", tcyc_b, obs_b, ms(tcyc_b));
    rst_b = 1'b0;
    #1;
    check("small_rst_now", 0, obs_b, ms(0));
    repeat (5) begin
      @(negedge gpu_clk);
      check("small_rst_hold", 0, obs_b, ms(0));
    end
    rst_b = 1'b1;
    #1;
    for (int c = 0; c < 40; c++) begin
      wait_b(c);
      check("small_restart", c, obs_b, ms(c));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
